// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side inputs, register file port and execute-side bundle of operand_fetch
interface operand_fetch_if #(
  parameter int CtrlWidth = 16
);
  logic                 iValid, oReady;
  logic [4:0]           iRs1Addr, iRs2Addr, iRdAddr;
  logic                 iUseRs1, iUseRs2, iRdWrite;
  logic [31:0]          iPc, iImm;
  logic [CtrlWidth-1:0] iCtrl;
  logic [4:0]           oAddr_Rs1, oAddr_Rs2;
  logic [31:0]          iRs1Data, iRs2Data;
  logic                 iWbValid;
  logic [4:0]           iWbAddr;
  logic [31:0]          iWbData;
  logic                 iSqValid;
  logic [4:0]           iSqAddr;
  logic                 iFlush;
  logic                 oValid, iReady;
  logic [31:0]          oRs1, oRs2, oPc, oImm;
  logic [4:0]           oRdAddr;
  logic                 oRdWrite;
  logic [CtrlWidth-1:0] oCtrl;
  modport master (
    output iValid, iRs1Addr, iRs2Addr, iRdAddr, iUseRs1, iUseRs2, iRdWrite, iPc, iImm, iCtrl,
           iRs1Data, iRs2Data, iWbValid, iWbAddr, iWbData, iSqValid, iSqAddr, iFlush, iReady,
    input  oReady, oAddr_Rs1, oAddr_Rs2, oValid, oRs1, oRs2, oPc, oImm, oRdAddr, oRdWrite, oCtrl
  );
  modport slave (
    input  iValid, iRs1Addr, iRs2Addr, iRdAddr, iUseRs1, iUseRs2, iRdWrite, iPc, iImm, iCtrl,
           iRs1Data, iRs2Data, iWbValid, iWbAddr, iWbData, iSqValid, iSqAddr, iFlush, iReady,
    output oReady, oAddr_Rs1, oAddr_Rs2, oValid, oRs1, oRs2, oPc, oImm, oRdAddr, oRdWrite, oCtrl
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: RV32 operand fetch with busy scoreboard; define OPERAND_FETCH_BYPASS_EN to forward writeback data
module operand_fetch #(
  parameter int NRegs = 32
) (
  input logic iClk,
  input logic nRst,
  operand_fetch_if.slave bus
);
  localparam logic [NRegs-1:0] One = 1;
  logic [NRegs-1:0] busy, setv, clrv;
  logic rs1nz, rs2nz, byp1, byp2, hz1, hz2, waw, accept;
  logic [31:0] op1, op2;
  assign bus.oAddr_Rs1 = bus.iRs1Addr;
  assign bus.oAddr_Rs2 = bus.iRs2Addr;
  assign rs1nz = |bus.iRs1Addr;
  assign rs2nz = |bus.iRs2Addr;
`ifdef OPERAND_FETCH_BYPASS_EN
  assign byp1 = bus.iWbValid & (bus.iWbAddr == bus.iRs1Addr) & rs1nz;
  assign byp2 = bus.iWbValid & (bus.iWbAddr == bus.iRs2Addr) & rs2nz;
  assign hz1 = bus.iUseRs1 & rs1nz & busy[bus.iRs1Addr] & !byp1;
  assign hz2 = bus.iUseRs2 & rs2nz & busy[bus.iRs2Addr] & !byp2;
`else
  // the register file write lands this edge, so a same-cycle writeback still stalls
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign hz1 = bus.iUseRs1 & rs1nz & (busy[bus.iRs1Addr] | (bus.iWbValid & (bus.iWbAddr == bus.iRs1Addr)));
  assign hz2 = bus.iUseRs2 & rs2nz & (busy[bus.iRs2Addr] | (bus.iWbValid & (bus.iWbAddr == bus.iRs2Addr)));
`endif
  assign waw = bus.iRdWrite & (|bus.iRdAddr) & busy[bus.iRdAddr];
  assign bus.oReady = !(hz1 | hz2 | waw) & (!bus.oValid | bus.iReady) & !bus.iFlush;
  assign accept = bus.iValid & bus.oReady;
  assign op1 = !rs1nz ? '0 : byp1 ? bus.iWbData : bus.iRs1Data;
  assign op2 = !rs2nz ? '0 : byp2 ? bus.iWbData : bus.iRs2Data;
  assign setv = (accept & bus.iRdWrite) ? One << bus.iRdAddr : '0;
  assign clrv = (bus.iWbValid ? One << bus.iWbAddr : '0)
              | (bus.iSqValid ? One << bus.iSqAddr : '0)
              | ((bus.iFlush & bus.oValid & bus.oRdWrite) ? One << bus.oRdAddr : '0);
  always_ff @(posedge iClk or negedge nRst)
    if (!nRst) begin
      busy <= '0;
      bus.oValid <= 1'b0;
      bus.oRs1 <= '0;
      bus.oRs2 <= '0;
      bus.oPc <= '0;
      bus.oImm <= '0;
      bus.oRdAddr <= '0;
      bus.oRdWrite <= 1'b0;
      bus.oCtrl <= '0;
    end else begin
      busy <= (setv | (busy & ~clrv)) & ~One;
      bus.oValid <= !bus.iFlush & (accept | (bus.oValid & !bus.iReady));
      if (accept) begin
        bus.oRs1 <= op1;
        bus.oRs2 <= op2;
        bus.oPc <= bus.iPc;
        bus.oImm <= bus.iImm;
        bus.oRdAddr <= bus.iRdAddr;
        bus.oRdWrite <= bus.iRdWrite;
        bus.oCtrl <= bus.iCtrl;
      end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed scoreboard bench for operand_fetch
module tb_operand_fetch;
  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;
  operand_fetch_if #(.CtrlWidth(16)) bus ();
  operand_fetch #(.NRegs(32)) dut (.iClk(iClk), .nRst(nRst), .bus(bus));
  logic [31:0] rf [32];
  assign bus.iRs1Data = rf[bus.oAddr_Rs1];
  assign bus.iRs2Data = rf[bus.oAddr_Rs2];
  always @(posedge iClk)
    if (!nRst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
      rf[0] <= 32'hDEAD_0000;
    end else if (bus.iWbValid && bus.iWbAddr != 0) rf[bus.iWbAddr] <= bus.iWbData;
  int vectors = 0;
  int errs = 0;
  logic [159:0] sb [$];
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [159:0] pk(input logic [31:0] a, b, pc, imm, input logic [4:0] rd, input logic w, input logic [15:0] c);
    return {10'b0, a, b, pc, imm, rd, w, c};
  endfunction
  function automatic logic [159:0] obs_b();
    return pk(bus.oRs1, bus.oRs2, bus.oPc, bus.oImm, bus.oRdAddr, bus.oRdWrite, bus.oCtrl);
  endfunction
  task automatic rdy(input string tag, input logic exp);
    #1 chk(tag, bus.oReady, exp);
  endtask
  task automatic iss(input logic [4:0] r1, r2, rd, input logic u1, u2, w, input logic [31:0] pc);
    bus.iValid = 1'b1; bus.iRs1Addr = r1; bus.iRs2Addr = r2; bus.iRdAddr = rd;
    bus.iUseRs1 = u1; bus.iUseRs2 = u2; bus.iRdWrite = w;
    bus.iPc = pc; bus.iImm = pc ^ 32'hFFFF_0000; bus.iCtrl = pc[15:0] ^ 16'hA5A5;
  endtask
  task automatic idle();
    bus.iValid = 1'b0; bus.iRs1Addr = '0; bus.iRs2Addr = '0; bus.iRdAddr = '0;
    bus.iUseRs1 = 1'b0; bus.iUseRs2 = 1'b0; bus.iRdWrite = 1'b0;
    bus.iPc = '0; bus.iImm = '0; bus.iCtrl = '0;
    bus.iWbValid = 1'b0; bus.iWbAddr = '0; bus.iWbData = '0;
    bus.iSqValid = 1'b0; bus.iSqAddr = '0; bus.iFlush = 1'b0;
  endtask
  task automatic exp_push(input logic [31:0] a, b);
    sb.push_back(pk(a, b, bus.iPc, bus.iImm, bus.iRdAddr, bus.iRdWrite, bus.iCtrl));
  endtask
  task automatic tick();
    if (bus.oValid && bus.iFlush) begin
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (bus.oValid && bus.iReady) begin
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL unexpected_bundle observed=%0h expected=none", obs_b());
      end else chk("bundle", obs_b(), sb.pop_front());
    end
    @(posedge iClk);
    #1;
  endtask
  initial begin
    idle();
    bus.iReady = 1'b1;
    repeat (2) @(posedge iClk);
    #1 nRst = 1'b1;
    chk("rst_oValid", bus.oValid, 0);
    chk("rst_bundle", obs_b(), 0);
    chk("rst_busy", dut.busy, 0);
    rdy("rst_oReady", 1);
    iss(0, 0, 1, 0, 0, 1, 32'h100); rdy("addi_rdy", 1); exp_push(0, 0); tick();
    chk("addi_valid", bus.oValid, 1);
    chk("addi_busy1", dut.busy[1], 1);
    iss(1, 1, 2, 1, 1, 1, 32'h104); rdy("raw_stall", 0);
    chk("oAddr_Rs1", bus.oAddr_Rs1, 1);
    tick();
    rdy("raw_stall2", 0);
    bus.iWbValid = 1'b1; bus.iWbAddr = 5'd1; bus.iWbData = 32'hA5;
`ifdef OPERAND_FETCH_BYPASS_EN
    rdy("raw_bypass", 1); exp_push(32'hA5, 32'hA5); tick();
    bus.iWbValid = 1'b0;
`else
    rdy("raw_wb_cycle", 0); tick();
    bus.iWbValid = 1'b0;
    rdy("raw_after_wb", 1); exp_push(32'hA5, 32'hA5); tick();
`endif
    chk("raw_busy", dut.busy[2:1], 2'b10);
    iss(0, 0, 5, 0, 0, 1, 32'h108); rdy("rd5_rdy", 1); exp_push(0, 0); tick();
    iss(0, 7, 0, 1, 1, 0, 32'h10C); rdy("x0_rdy", 1); exp_push(0, 32'h1007); tick();
    iss(2, 0, 0, 0, 1, 0, 32'h110); rdy("unused_rdy", 1); exp_push(32'h1002, 0); tick();
    iss(0, 0, 3, 0, 0, 1, 32'h114); rdy("waw_first", 1); exp_push(0, 0); tick();
    iss(0, 0, 3, 0, 0, 1, 32'h118); rdy("waw_stall", 0); tick();
    bus.iSqValid = 1'b1; bus.iSqAddr = 5'd3;
    rdy("waw_sq_cycle", 0); tick();
    rdy("waw_accept", 1); exp_push(0, 0); tick();
    bus.iSqValid = 1'b0;
    chk("waw_busy3", dut.busy[3], 1);
    iss(7, 7, 0, 1, 1, 0, 32'h11C); rdy("bp_a_rdy", 1); exp_push(32'h1007, 32'h1007); tick();
    bus.iReady = 1'b0;
    iss(0, 0, 9, 0, 0, 1, 32'h120);
    for (int k = 0; k < 3; k++) begin
      rdy("bp_rdy", 0);
      chk("bp_valid", bus.oValid, 1);
      chk("bp_hold", obs_b(), sb[0]);
      tick();
    end
    bus.iReady = 1'b1;
    rdy("bp_release", 1); exp_push(0, 0); tick();
    iss(0, 0, 4, 0, 0, 1, 32'h124); rdy("rd4_rdy", 1); exp_push(0, 0); tick();
    bus.iFlush = 1'b1;
    iss(0, 0, 10, 0, 0, 1, 32'h128); rdy("flush_rdy", 0); tick();
    idle();
    chk("flush_valid", bus.oValid, 0);
    chk("flush_busy4", dut.busy[4], 0);
    chk("flush_busy9", dut.busy[9], 1);
    iss(0, 0, 8, 0, 0, 1, 32'h12C); rdy("rd8_rdy", 1); exp_push(0, 0); tick();
    bus.iReady = 1'b0;
    iss(8, 0, 11, 1, 0, 1, 32'h130); rdy("pre_rst_stall", 0); tick();
    rdy("pre_rst_stall2", 0);
    #1 nRst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.oValid, 0);
    chk("mid_rst_bundle", obs_b(), 0);
    chk("mid_rst_busy", dut.busy, 0);
    sb.delete();
    @(posedge iClk);
    #1 nRst = 1'b1;
    idle();
    bus.iReady = 1'b1;
    rdy("post_rst_rdy", 1);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
